// File: rtl/spiart_pkg.sv
// Shared command encodings, FSM states and the reply descriptor for the
// UART-command to SPI-master bridge.
package spiart_pkg;

  localparam logic [7:0] CMD_SETCFG = "X";
  localparam logic [7:0] CMD_GETCFG = "x";
  localparam logic [7:0] CMD_SETDIV = "C";
  localparam logic [7:0] CMD_GETDIV = "c";
  localparam logic [7:0] CMD_SETCS  = "S";
  localparam logic [7:0] CMD_GETCS  = "s";
  localparam logic [7:0] CMD_BURST  = "B";
  localparam logic [7:0] CMD_NL     = 8'h0A;
  localparam logic [7:0] CMD_ERR    = "?";

  typedef enum logic [3:0] {
    QUIET, IDLE, ARG, LEN, DATA, SPI_START, SPI_WAIT,
    TX1_START, TX1_WAIT, TX2_START, TX2_WAIT, ERROR
  } state_t;

  // Pending UART reply: one or two bytes, then resume in ret.
  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic       two;
    state_t     ret;
  } reply_t;

  function automatic reply_t mk_reply(input logic [7:0] b1, input logic [7:0] b2,
                                      input logic two, input state_t ret);
    reply_t r;
    r.b1  = b1;
    r.b2  = b2;
    r.two = two;
    r.ret = ret;
    return r;
  endfunction

endpackage

// File: rtl/spiart_fifo.sv
// Show-ahead synchronous byte FIFO: dout presents the head entry while not empty.
module spiart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spiart_bridge.sv
// UART-command to SPI-master bridge: decodes buffered UART command bytes,
// drives SPI config/GPIO/chip selects and runs length-prefixed SPI bursts.
module spiart_bridge
  import spiart_pkg::*;
#(
  parameter int NCS        = 4,
  parameter int NGPIO      = 3,
  parameter int DIV_INIT   = 255,
  parameter int MAXLEN     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             cpol,
  output logic             cpha,
  output logic [7:0]       divparam,
  output logic [NGPIO-1:0] genio,
  output logic [NCS-1:0]   spi_cs_n,
  input  logic             uart_ready,
  input  logic             uart_rxerr,
  input  logic [7:0]       uart_rx,
  output logic             uart_start,
  input  logic             uart_busy,
  output logic [7:0]       uart_tx,
  output logic [7:0]       spi_tx,
  output logic             spi_start,
  input  logic             spi_busy,
  input  logic [7:0]       spi_rx
);
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  state_t           state, state_d;
  reply_t           rep, rep_d;
  logic [7:0]       cmd, cmd_d, cnt, cnt_d, divp_d, spi_tx_d, xstat;
  logic             cpol_d, cpha_d, cs_act, cs_act_d, in_err, in_err_d;
  logic [NGPIO-1:0] genio_d;
  logic [CSW-1:0]   cs_sel, cs_sel_d;
  logic [NCS-1:0]   cs_mask;
  logic [TW-1:0]    tmo_cnt;
  logic             err, ovf, fail, tmo_hit, waiting;
  logic             push, pop, flush, cs_now;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;

  // A framing error in the same cycle as a byte wins and drops the byte.
  assign push    = uart_ready & ~uart_rxerr;
  assign flush   = (state == ERROR);
  assign fail    = err | ovf;
  assign tmo_hit = (tmo_cnt == TMAX);
  assign waiting = (state inside {ARG, LEN, DATA});

  spiart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (uart_rx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign uart_start = (state inside {TX1_START, TX2_START});
  assign spi_start  = (state == SPI_START);
  assign uart_tx    = (state inside {TX2_START, TX2_WAIT}) ? rep.b2 : rep.b1;

  // Chip select drops combinationally in the cycle the burst length is accepted.
  always_comb begin
    cs_mask         = '0;
    cs_mask[cs_sel] = cs_act | cs_now;
  end
  assign spi_cs_n = ~cs_mask;

  always_comb begin
    xstat                = '0;
    xstat[NGPIO+1:0]     = {genio, cpha, cpol};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      ovf <= 1'b0;
    end else if (flush) begin
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (uart_rxerr)          err <= 1'b1;
      if (push && fifo_full)   ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    tmo_cnt <= '0;
    else if (pop)                                  tmo_cnt <= '0;
    else if (waiting && fifo_empty && !tmo_hit)    tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_comb begin
    state_d  = state;
    rep_d    = rep;
    cmd_d    = cmd;
    cnt_d    = cnt;
    cpol_d   = cpol;
    cpha_d   = cpha;
    genio_d  = genio;
    divp_d   = divparam;
    cs_sel_d = cs_sel;
    cs_act_d = cs_act;
    spi_tx_d = spi_tx;
    in_err_d = in_err;
    pop      = 1'b0;
    cs_now   = 1'b0;
    case (state)
      QUIET: if (!spi_busy && !uart_busy) state_d = IDLE;
      IDLE: begin
        if (fail) state_d = ERROR;
        else if (!fifo_empty) begin
          pop   = 1'b1;
          cmd_d = fifo_dout;
          state_d = TX1_START;
          case (fifo_dout)
            CMD_SETCFG, CMD_SETDIV, CMD_SETCS: state_d = ARG;
            CMD_BURST:  state_d = LEN;
            CMD_GETCFG: rep_d = mk_reply(fifo_dout, xstat, 1'b1, IDLE);
            CMD_GETDIV: rep_d = mk_reply(fifo_dout, divparam, 1'b1, IDLE);
            CMD_GETCS:  rep_d = mk_reply(fifo_dout, 8'(cs_sel), 1'b1, IDLE);
            CMD_NL:     rep_d = mk_reply(CMD_NL, CMD_NL, 1'b1, IDLE);
            default:    state_d = ERROR;
          endcase
        end
      end
      ARG: begin
        if (fail) state_d = ERROR;
        else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = TX1_START;
          case (cmd)
            CMD_SETCFG: begin
              cpol_d  = fifo_dout[0];
              cpha_d  = fifo_dout[1];
              genio_d = fifo_dout[NGPIO+1:2];
              rep_d   = mk_reply(cmd, fifo_dout, 1'b1, IDLE);
            end
            CMD_SETDIV: begin
              divp_d = (fifo_dout == 8'd0) ? 8'd1 : fifo_dout;
              rep_d  = mk_reply(cmd, divp_d, 1'b1, IDLE);
            end
            default: begin
              if (int'(fifo_dout) < NCS) begin
                cs_sel_d = fifo_dout[CSW-1:0];
                rep_d    = mk_reply(cmd, fifo_dout, 1'b1, IDLE);
              end else state_d = ERROR;
            end
          endcase
        end else if (tmo_hit) state_d = ERROR;
      end
      LEN: begin
        if (fail) state_d = ERROR;
        else if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_dout == 8'd0 || int'(fifo_dout) > MAXLEN) state_d = ERROR;
          else begin
            cnt_d    = fifo_dout;
            cs_act_d = 1'b1;
            cs_now   = 1'b1;
            rep_d    = mk_reply(CMD_BURST, 8'd0, 1'b0, DATA);
            state_d  = TX1_START;
          end
        end else if (tmo_hit) state_d = ERROR;
      end
      DATA: begin
        if (fail) state_d = ERROR;
        else if (!fifo_empty) begin
          pop      = 1'b1;
          spi_tx_d = fifo_dout;
          cnt_d    = cnt - 8'd1;
          state_d  = SPI_START;
        end else if (tmo_hit) state_d = ERROR;
      end
      SPI_START: if (spi_busy) state_d = SPI_WAIT;
      SPI_WAIT: begin
        if (!spi_busy) begin
          if (cnt == 8'd0) cs_act_d = 1'b0;
          if (fail) state_d = ERROR;
          else begin
            rep_d   = mk_reply(spi_rx, 8'd0, 1'b0, (cnt == 8'd0) ? IDLE : DATA);
            state_d = TX1_START;
          end
        end
      end
      TX1_START: if (uart_busy) state_d = TX1_WAIT;
      TX1_WAIT: begin
        // The error reply itself is never interrupted; later faults are caught in IDLE.
        if (!uart_busy) begin
          if (fail && !in_err) state_d = ERROR;
          else if (rep.two)    state_d = TX2_START;
          else                 state_d = rep.ret;
        end
      end
      TX2_START: if (uart_busy) state_d = TX2_WAIT;
      TX2_WAIT: begin
        if (!uart_busy) begin
          in_err_d = 1'b0;
          state_d  = rep.ret;
        end
      end
      ERROR: begin
        cs_act_d = 1'b0;
        cnt_d    = 8'd0;
        in_err_d = 1'b1;
        rep_d    = mk_reply(CMD_ERR, CMD_ERR, 1'b1, IDLE);
        state_d  = TX1_START;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= QUIET;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep      <= '0;
      cmd      <= 8'd0;
      cnt      <= 8'd0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      genio    <= '0;
      divparam <= 8'(DIV_INIT);
      cs_sel   <= '0;
      cs_act   <= 1'b0;
      spi_tx   <= 8'd0;
      in_err   <= 1'b0;
    end else begin
      rep      <= rep_d;
      cmd      <= cmd_d;
      cnt      <= cnt_d;
      cpol     <= cpol_d;
      cpha     <= cpha_d;
      genio    <= genio_d;
      divparam <= divp_d;
      cs_sel   <= cs_sel_d;
      cs_act   <= cs_act_d;
      spi_tx   <= spi_tx_d;
      in_err   <= in_err_d;
    end
  end

endmodule
